uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: parity mode and receiver FSM state.
// Also holds the 2-of-3 majority helper used by the bit sampler.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   function automatic logic maj3(
      input logic a,
      input logic b,
      input logic c
   );
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, count-based full/empty, registered occupancy.
// Ports: clk, rst, push/push_data/full, pop/pop_data/empty, count.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign do_pop  = pop && !empty;
   // a pop frees the slot the full-FIFO push writes into
   assign do_push = push && (!full || do_pop);

   // head is gated so an empty FIFO always presents zero
   assign pop_data = empty ? '0 : mem[rd_q];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_q] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push)
            wr_q <= wr_q + 1'b1;
         if (do_pop)
            rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop)
            cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push)
            cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, parity/stop/break checks
// and a receive FIFO. Ports: clk, rst, ser_in, out_data/out_valid/
// out_ready, fifo_count, frame_err/parity_err/overrun_err, err_clr, busy.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int      CLKS_PER_BIT = 434,
   parameter int      DATA_BITS    = 8,
   parameter parity_t PARITY       = PAR_NONE,
   parameter int      STOP_BITS    = 1,
   parameter int      FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ser_in,
   output logic [DATA_BITS-1:0]          out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun_err,
   input  logic                          err_clr,
   output logic                          busy
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] SMP_A     = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] SMP_B     = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] SMP_C     = 16'(CLKS_PER_BIT / 2 + 1);
   localparam logic [3:0]  DBIT_LAST = 4'(DATA_BITS - 1);

   logic [1:0]           sync_q;
   logic                 rx;
   rx_state_t            state_q;
   rx_state_t            state_d;
   logic [15:0]          cnt_q;
   logic [3:0]           bit_q;
   logic                 stop_q;
   logic                 smp_a_q;
   logic                 smp_b_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bad_q;

   logic bit_end;
   logic mid;
   logic maj;
   logic last_stop;
   logic exp_par;
   logic push;
   logic pop;
   logic full;
   logic empty;
   logic frame_set;
   logic par_set;
   logic ovr_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sync_q <= 2'b11;
      else
         sync_q <= {sync_q[0], ser_in};
   end

   assign rx = sync_q[1];

   assign bit_end   = (cnt_q == BIT_LAST);
   // third sample arrives live, so the vote resolves on this count
   assign mid       = (cnt_q == SMP_C);
   assign maj       = maj3(smp_a_q, smp_b_q, rx);
   assign last_stop = (STOP_BITS == 1) || stop_q;
   assign exp_par   = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= RX_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX_IDLE:
            if (!rx)
               state_d = RX_START;
         RX_START:
            if (mid && maj)
               state_d = RX_IDLE;
            else if (bit_end)
               state_d = RX_DATA;
         RX_DATA:
            if (bit_end && bit_q == DBIT_LAST)
               state_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
         RX_PARITY:
            if (bit_end)
               state_d = RX_STOP;
         RX_STOP:
            if (mid) begin
               if (!maj)
                  state_d = (shift_q == '0) ? RX_BREAK : RX_IDLE;
               else if (last_stop)
                  state_d = RX_IDLE;
            end
         RX_BREAK:
            if (rx)
               state_d = RX_IDLE;
         default:
            state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != RX_IDLE);
      push      = 1'b0;
      frame_set = 1'b0;
      par_set   = 1'b0;
      if (state_q == RX_STOP && mid) begin
         frame_set = !maj;
         push      = maj && last_stop && !par_bad_q;
      end
      if (state_q == RX_PARITY && mid)
         par_set = (maj != exp_par);
   end

   assign pop       = out_valid && out_ready;
   assign out_valid = !empty;
   assign ovr_set   = push && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_q     <= '0;
         stop_q    <= 1'b0;
         smp_a_q   <= 1'b0;
         smp_b_q   <= 1'b0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         // bit timer restarts on every bit and every state change
         if (state_d != state_q || bit_end ||
             state_q == RX_IDLE || state_q == RX_BREAK)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + 16'd1;
         if (cnt_q == SMP_A)
            smp_a_q <= rx;
         if (cnt_q == SMP_B)
            smp_b_q <= rx;
         if (state_q == RX_IDLE) begin
            bit_q     <= '0;
            stop_q    <= 1'b0;
            par_bad_q <= 1'b0;
         end
         if (state_q == RX_DATA) begin
            if (mid)
               shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            if (bit_end)
               bit_q <= bit_q + 4'd1;
         end
         if (par_set)
            par_bad_q <= 1'b1;
         if (state_q == RX_STOP && bit_end)
            stop_q <= 1'b1;
      end
   end

   // a new error event outranks a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_err   <= frame_set | (frame_err   & ~err_clr);
         parity_err  <= par_set   | (parity_err  & ~err_clr);
         overrun_err <= ovr_set   | (overrun_err & ~err_clr);
      end
   end

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shift_q),
      .full      (full),
      .pop       (pop),
      .pop_data  (out_data),
      .empty     (empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and an 8E1 instance, random payloads
// compared against a frame-level reference model held in queues.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          ser_n = 1'b1, ser_e = 1'b1;
   logic [7:0]    data_n, data_e;
   logic          valid_n, valid_e;
   logic          ready_n = 1'b0, ready_e = 1'b0;
   logic [CW-1:0] count_n, count_e;
   logic          fe_n, pe_n, oe_n, fe_e, pe_e, oe_e;
   logic          clr_n = 1'b0, clr_e = 1'b0;
   logic          busy_n, busy_e;

   int tests_run = 0;
   int failed    = 0;
   int t_start   = 0;
   int rise_n    = -1;
   logic pv_n    = 1'b0;

   logic [7:0] got_n[$];
   logic [7:0] got_e[$];

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8),
      .PARITY       (PAR_NONE),
      .STOP_BITS    (1),
      .FIFO_DEPTH   (DEPTH)
   ) dut_n (
      .clk         (clk),
      .rst         (rst),
      .ser_in      (ser_n),
      .out_data    (data_n),
      .out_valid   (valid_n),
      .out_ready   (ready_n),
      .fifo_count  (count_n),
      .frame_err   (fe_n),
      .parity_err  (pe_n),
      .overrun_err (oe_n),
      .err_clr     (clr_n),
      .busy        (busy_n)
   );

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8),
      .PARITY       (PAR_EVEN),
      .STOP_BITS    (1),
      .FIFO_DEPTH   (DEPTH)
   ) dut_e (
      .clk         (clk),
      .rst         (rst),
      .ser_in      (ser_e),
      .out_data    (data_e),
      .out_valid   (valid_e),
      .out_ready   (ready_e),
      .fifo_count  (count_e),
      .frame_err   (fe_e),
      .parity_err  (pe_e),
      .overrun_err (oe_e),
      .err_clr     (clr_e),
      .busy        (busy_e)
   );

   always @(negedge clk) begin
      if (!rst && valid_n && ready_n) got_n.push_back(data_n);
      if (!rst && valid_e && ready_e) got_e.push_back(data_e);
      if (!rst && valid_n && !pv_n && rise_n < 0) rise_n = cyc;
      pv_n = valid_n;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // drive one frame; optional one-cycle glitch in data bit gbit at offset goff
   task automatic send(input bit sel, input logic [7:0] d,
                       input bit use_par, input bit par_bad,
                       input int gbit, input int goff);
      bit bits[$];
      bit v;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (use_par) bits.push_back((^d) ^ par_bad);
      bits.push_back(1'b1);
      for (int j = 0; j < bits.size(); j++) begin
         for (int m = 0; m < CPB; m++) begin
            @(posedge clk);
            #1;
            if (j == 0 && m == 0) t_start = cyc;
            v = bits[j] ^ ((j == gbit + 1) && (m == goff));
            if (sel) ser_e = v;
            else     ser_n = v;
         end
      end
   endtask

   task automatic clear_flags();
      clr_n = 1'b1;
      clr_e = 1'b1;
      wait_cyc(1);
      clr_n = 1'b0;
      clr_e = 1'b0;
      wait_cyc(1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cyc(3);
      tests_run++;
      if (count_n !== '0 || valid_n !== 1'b0 || data_n !== 8'h00) begin
         failed++;
         $display("FAIL reset_fifo: count=%0d valid=%b data=%h want 0 0 00",
                  count_n, valid_n, data_n);
      end
      tests_run++;
      if ({fe_n, pe_n, oe_n, busy_n} !== 4'b0000) begin
         failed++;
         $display("FAIL reset_flags: fe/pe/oe/busy=%b want 0000",
                  {fe_n, pe_n, oe_n, busy_n});
      end
      tests_run++;
      if ({fe_e, pe_e, oe_e, busy_e, valid_e} !== 5'b00000) begin
         failed++;
         $display("FAIL reset_even: flags=%b want 00000",
                  {fe_e, pe_e, oe_e, busy_e, valid_e});
      end
      rst = 1'b0;
      wait_cyc(4);
   endtask

   task automatic test_basic();
      int lat;
      ready_n = 1'b1;
      got_n.delete();
      rise_n = -1;
      send(1'b0, 8'hA5, 1'b0, 1'b0, -1, 0);
      lat = rise_n - t_start;
      send(1'b0, 8'h3C, 1'b0, 1'b0, -1, 0);
      wait_cyc(20);
      // stop mid-sample on the line is 9.5 bits in; allow sync + vote latency
      tests_run++;
      if (lat < 9 * CPB + CPB / 2 + 2 || lat > 9 * CPB + CPB / 2 + 6) begin
         failed++;
         $display("FAIL basic_latency: got %0d cycles want %0d..%0d",
                  lat, 9 * CPB + CPB / 2 + 2, 9 * CPB + CPB / 2 + 6);
      end
      tests_run++;
      if (got_n.size() != 2) begin
         failed++;
         $display("FAIL basic_count: got %0d bytes want 2", got_n.size());
      end else begin
         tests_run++;
         if (got_n[0] !== 8'hA5 || got_n[1] !== 8'h3C) begin
            failed++;
            $display("FAIL basic_data: got %h %h want a5 3c",
                     got_n[0], got_n[1]);
         end
      end
      tests_run++;
      if ({fe_n, pe_n, oe_n} !== 3'b000) begin
         failed++;
         $display("FAIL basic_flags: got %b want 000", {fe_n, pe_n, oe_n});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[$];
      logic [7:0] b;
      ready_n = 1'b1;
      got_n.delete();
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         exp.push_back(b);
         send(1'b0, b, 1'b0, 1'b0, -1, 0);
      end
      wait_cyc(20);
      tests_run++;
      if (got_n != exp) begin
         failed++;
         $display("FAIL b2b_stream: got %p want %p", got_n, exp);
      end
   endtask

   task automatic test_parity();
      logic [7:0] exp[$];
      logic [7:0] b;
      ready_e = 1'b1;
      got_e.delete();
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         exp.push_back(b);
         send(1'b1, b, 1'b1, 1'b0, -1, 0);
      end
      wait_cyc(10);
      tests_run++;
      if (got_e != exp || pe_e !== 1'b0) begin
         failed++;
         $display("FAIL parity_good: got %p pe=%b want %p pe=0",
                  got_e, pe_e, exp);
      end
      ready_e = 1'b0;
      send(1'b1, 8'h07, 1'b1, 1'b1, -1, 0);
      wait_cyc(10);
      tests_run++;
      if (pe_e !== 1'b1 || count_e !== '0) begin
         failed++;
         $display("FAIL parity_bad: pe=%b count=%0d want 1 0", pe_e, count_e);
      end
      clear_flags();
      tests_run++;
      if (pe_e !== 1'b0) begin
         failed++;
         $display("FAIL parity_clr: pe=%b want 0", pe_e);
      end
   endtask

   task automatic test_overrun();
      logic [7:0] exp[$];
      logic [7:0] b;
      bit ovr;
      ovr = 1'b0;
      ready_n = 1'b0;
      got_n.delete();
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         if (exp.size() < DEPTH) exp.push_back(b);
         else ovr = 1'b1;
         send(1'b0, b, 1'b0, 1'b0, -1, 0);
      end
      wait_cyc(10);
      tests_run++;
      if (count_n !== CW'(exp.size()) || oe_n !== ovr) begin
         failed++;
         $display("FAIL overrun_state: count=%0d oe=%b want %0d %b",
                  count_n, oe_n, exp.size(), ovr);
      end
      tests_run++;
      if (data_n !== exp[0] || valid_n !== 1'b1) begin
         failed++;
         $display("FAIL overrun_hold: data=%h valid=%b want %h 1",
                  data_n, valid_n, exp[0]);
      end
      ready_n = 1'b1;
      wait_cyc(10);
      tests_run++;
      if (got_n != exp) begin
         failed++;
         $display("FAIL overrun_drain: got %p want %p", got_n, exp);
      end
      clear_flags();
      tests_run++;
      if (oe_n !== 1'b0) begin
         failed++;
         $display("FAIL overrun_clr: oe=%b want 0", oe_n);
      end
   endtask

   task automatic test_break();
      ready_n = 1'b1;
      got_n.delete();
      ser_n = 1'b0;
      wait_cyc(12 * CPB);
      tests_run++;
      if (fe_n !== 1'b1 || busy_n !== 1'b1 || count_n !== '0) begin
         failed++;
         $display("FAIL break_hold: fe=%b busy=%b count=%0d want 1 1 0",
                  fe_n, busy_n, count_n);
      end
      ser_n = 1'b1;
      wait_cyc(6);
      tests_run++;
      if (busy_n !== 1'b0 || got_n.size() != 0) begin
         failed++;
         $display("FAIL break_release: busy=%b pushed=%0d want 0 0",
                  busy_n, got_n.size());
      end
      clear_flags();
      send(1'b0, 8'h55, 1'b0, 1'b0, -1, 0);
      wait_cyc(10);
      tests_run++;
      if (got_n.size() != 1 || got_n[0] !== 8'h55 || fe_n !== 1'b0) begin
         failed++;
         $display("FAIL break_next: got %p fe=%b want '{55} 0", got_n, fe_n);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] exp[$];
      logic [7:0] b;
      ready_n = 1'b1;
      got_n.delete();
      ser_n = 1'b0;
      wait_cyc(3);
      ser_n = 1'b1;
      wait_cyc(2 * CPB);
      tests_run++;
      if (busy_n !== 1'b0 || got_n.size() != 0 ||
          {fe_n, pe_n, oe_n} !== 3'b000) begin
         failed++;
         $display("FAIL false_start: busy=%b pushed=%0d flags=%b want 0 0 000",
                  busy_n, got_n.size(), {fe_n, pe_n, oe_n});
      end
      // each glitch lands on exactly one of the three mid-bit samples
      for (int k = 0; k < 3; k++) begin
         b = 8'($urandom);
         exp.push_back(b);
         send(1'b0, b, 1'b0, 1'b0, int'($urandom_range(0, 7)),
              CPB / 2 + k);
      end
      wait_cyc(10);
      tests_run++;
      if (got_n != exp) begin
         failed++;
         $display("FAIL glitch_vote: got %p want %p", got_n, exp);
      end
   endtask

   task automatic test_reset_mid();
      ready_n = 1'b0;
      got_n.delete();
      send(1'b0, 8'($urandom), 1'b0, 1'b0, -1, 0);
      send(1'b0, 8'($urandom), 1'b0, 1'b0, -1, 0);
      wait_cyc(5);
      tests_run++;
      if (count_n !== CW'(2)) begin
         failed++;
         $display("FAIL rstmid_queued: count=%0d want 2", count_n);
      end
      ser_n = 1'b0;
      wait_cyc(3 * CPB);
      rst = 1'b1;
      wait_cyc(2);
      tests_run++;
      if (count_n !== '0 || valid_n !== 1'b0 || busy_n !== 1'b0 ||
          {fe_n, pe_n, oe_n} !== 3'b000) begin
         failed++;
         $display("FAIL rstmid_clear: count=%0d valid=%b busy=%b flags=%b want 0",
                  count_n, valid_n, busy_n, {fe_n, pe_n, oe_n});
      end
      ser_n = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(4);
      ready_n = 1'b1;
      send(1'b0, 8'hFF, 1'b0, 1'b0, -1, 0);
      wait_cyc(10);
      tests_run++;
      if (got_n.size() != 1 || got_n[0] !== 8'hFF) begin
         failed++;
         $display("FAIL rstmid_next: got %p want '{ff}", got_n);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_parity();
      test_overrun();
      test_break();
      test_glitch();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
